// File: rtl/vga_pkg.sv
// Shared constants, mode encoding and colour table for the VGA test-pattern source.
package vga_pkg;

    localparam int unsigned H_VALID_DEF = 800;
    localparam int unsigned V_VALID_DEF = 600;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRAD    = 2'd2,
        MODE_BOUNCE  = 2'd3
    } mode_e;

    localparam logic [11:0] COL_WHITE   = 12'hFFF;
    localparam logic [11:0] COL_YELLOW  = 12'hFF0;
    localparam logic [11:0] COL_CYAN    = 12'h0FF;
    localparam logic [11:0] COL_GREEN   = 12'h0F0;
    localparam logic [11:0] COL_MAGENTA = 12'hF0F;
    localparam logic [11:0] COL_RED     = 12'hF00;
    localparam logic [11:0] COL_BLUE    = 12'h00F;
    localparam logic [11:0] COL_BLACK   = 12'h000;

    localparam logic [11:0] BOX_COLOR = 12'hFF0;
    localparam logic [11:0] BG_COLOR  = 12'h004;

    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

    // One axis of the bouncing box; returns {dir_up, pos}.
    function automatic logic [12:0] axis_next(input logic [11:0] pos, input logic dir_up,
                                              input logic [11:0] max, input logic [11:0] step);
        if (dir_up && (pos + step >= max)) return {1'b0, max};
        if (!dir_up && (pos <= step))      return {1'b1, 12'd0};
        if (dir_up)                        return {1'b1, pos + step};
        return {1'b0, pos - step};
    endfunction

endpackage

// File: rtl/vga_bounce_box.sv
// Bouncing-box position/direction state, advanced once per frame.
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int unsigned H_VALID  = H_VALID_DEF,
    parameter int unsigned V_VALID  = V_VALID_DEF,
    parameter int unsigned BOX_SIZE = 64,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [11:0] box_x,
    output logic [11:0] box_y
);

    localparam logic [11:0] MAX_X = 12'(H_VALID - BOX_SIZE);
    localparam logic [11:0] MAX_Y = 12'(V_VALID - BOX_SIZE);
    localparam logic [11:0] STEP  = 12'(BOX_STEP);

    logic dir_x, dir_y;
    logic [12:0] nx, ny;

    always_comb begin
        nx = axis_next(box_x, dir_x, MAX_X, STEP);
        ny = axis_next(box_y, dir_y, MAX_Y, STEP);
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= 12'd0;
            box_y <= 12'd0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (step) begin
            {dir_x, box_x} <= nx;
            {dir_y, box_y} <= ny;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: one-cycle registered lookup of four selectable patterns.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VALID  = H_VALID_DEF,
    parameter int unsigned V_VALID  = V_VALID_DEF,
    parameter int unsigned BOX_SIZE = 64,
    parameter int unsigned BOX_STEP = 2
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic        mode_next,
    output logic [11:0] pix_data,
    output logic [1:0]  mode,
    output logic        frame_tick
);

    localparam int unsigned BAR_W = H_VALID / 8;

    mode_e       mode_q;
    logic        pending;
    logic [7:0]  frame_cnt;
    logic [11:0] box_x, box_y;
    logic [2:0]  bar_idx;
    logic [11:0] pattern;
    logic        req_valid, last_req, in_box;

    assign req_valid = (pix_x < 12'(H_VALID)) && (pix_y < 12'(V_VALID));
    assign last_req  = (pix_x == 12'(H_VALID - 1)) && (pix_y == 12'(V_VALID - 1));
    assign in_box    = (pix_x >= box_x) && (pix_x < box_x + 12'(BOX_SIZE)) &&
                       (pix_y >= box_y) && (pix_y < box_y + 12'(BOX_SIZE));
    assign mode      = mode_q;

    // Smallest bar boundary above pix_x wins; avoids a divider.
    always_comb begin
        bar_idx = 3'd7;
        for (int i = 7; i >= 1; i--) begin
            if (pix_x < 12'(i * BAR_W)) bar_idx = 3'(i - 1);
        end
    end

    always_comb begin
        pattern = COL_BLACK;
        case (mode_q)
            MODE_BARS:    pattern = bar_color(bar_idx);
            MODE_CHECKER: pattern = (pix_x[5] ^ pix_y[5]) ? COL_WHITE : COL_BLACK;
            MODE_GRAD:    pattern = {pix_x[9:6], pix_y[9:6], frame_cnt[5:2]};
            MODE_BOUNCE:  pattern = in_box ? BOX_COLOR : BG_COLOR;
            default:      pattern = COL_BLACK;
        endcase
    end

    // frame_tick and all per-frame state updates share the same edge.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data   <= 12'h000;
            mode_q     <= MODE_BARS;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
            pending    <= 1'b0;
        end else begin
            pix_data   <= req_valid ? pattern : 12'h000;
            frame_tick <= last_req;
            if (last_req) begin
                frame_cnt <= frame_cnt + 8'd1;
                pending   <= 1'b0;
                if (pending || mode_next) mode_q <= mode_e'(mode_q + 2'd1);
            end else if (mode_next) begin
                pending <= 1'b1;
            end
        end
    end

    vga_bounce_box #(
        .H_VALID  (H_VALID),
        .V_VALID  (V_VALID),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .step    (last_req),
        .box_x   (box_x),
        .box_y   (box_y)
    );

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: vector table plus multi-cycle sequences.
module tb_vga_pattern_gen;

    logic        vga_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pix_x = 12'hFFF;
    logic [11:0] pix_y = 12'hFFF;
    logic        mode_next = 1'b0;
    logic [11:0] pix_data;
    logic [1:0]  mode;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail = 0;

    always #5 vga_clk = ~vga_clk;

    vga_pattern_gen dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .mode_next  (mode_next),
        .pix_data   (pix_data),
        .mode       (mode),
        .frame_tick (frame_tick)
    );

    typedef struct {
        string       name;
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] data;
        logic        tick;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one request, then sample its registered result 1 ns after the edge.
    task automatic req(input logic [11:0] x, input logic [11:0] y, input logic mn);
        @(negedge vga_clk);
        pix_x = x;
        pix_y = y;
        mode_next = mn;
        @(posedge vga_clk);
        #1;
        pix_x = 12'hFFF;
        pix_y = 12'hFFF;
        mode_next = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"bar0_left",     12'd0,   12'd0,   12'hFFF, 1'b0};
        vecs[1]  = '{"bar0_right",    12'd99,  12'd0,   12'hFFF, 1'b0};
        vecs[2]  = '{"bar1_left",     12'd100, 12'd0,   12'hFF0, 1'b0};
        vecs[3]  = '{"bar2",          12'd250, 12'd3,   12'h0FF, 1'b0};
        vecs[4]  = '{"bar3_right",    12'd399, 12'd10,  12'h0F0, 1'b0};
        vecs[5]  = '{"bar4",          12'd450, 12'd10,  12'hF0F, 1'b0};
        vecs[6]  = '{"bar5",          12'd550, 12'd10,  12'hF00, 1'b0};
        vecs[7]  = '{"bar6",          12'd650, 12'd599, 12'h00F, 1'b0};
        vecs[8]  = '{"bar7_last_col", 12'd799, 12'd0,   12'h000, 1'b0};
        vecs[9]  = '{"no_request",    12'hFFF, 12'hFFF, 12'h000, 1'b0};
        vecs[10] = '{"x_out_range",   12'd800, 12'd5,   12'h000, 1'b0};
        vecs[11] = '{"y_out_range",   12'd5,   12'd600, 12'h000, 1'b0};
        vecs[12] = '{"row598_col799", 12'd799, 12'd598, 12'h000, 1'b0};
        vecs[13] = '{"row599_col798", 12'd798, 12'd599, 12'h000, 1'b0};

        #12;
        check("reset_pix_data", pix_data, 12'h000);
        check("reset_mode", mode, 2'd0);
        check("reset_frame_tick", frame_tick, 1'b0);
        @(negedge vga_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req(vecs[i].x, vecs[i].y, 1'b0);
            check({vecs[i].name, "_data"}, pix_data, vecs[i].data);
            check({vecs[i].name, "_tick"}, frame_tick, vecs[i].tick);
        end
        check("bars_mode", mode, 2'd0);

        // Several mode_next pulses within one frame collapse to one advance.
        req(12'd10, 12'd10, 1'b0);
        req(12'd20, 12'd10, 1'b1);
        check("pend_mode_hold", mode, 2'd0);
        check("pend_set", dut.pending, 1'b1);
        req(12'd30, 12'd20, 1'b1);
        req(12'd0, 12'd300, 1'b0);
        req(12'd5, 12'd5, 1'b1);
        check("pend_mode_hold2", mode, 2'd0);
        req(12'd799, 12'd599, 1'b0);
        check("tick1_pulse", frame_tick, 1'b1);
        check("tick1_mode", mode, 2'd1);
        check("tick1_frame_cnt", dut.frame_cnt, 8'd1);
        check("tick1_box_x", dut.box_x, 12'd2);
        check("tick1_box_y", dut.box_y, 12'd2);
        check("tick1_pending", dut.pending, 1'b0);
        check("tick1_data", pix_data, 12'h000);
        req(12'hFFF, 12'hFFF, 1'b0);
        check("tick1_single", frame_tick, 1'b0);
        check("tick1_mode_kept", mode, 2'd1);

        req(12'd32, 12'd0, 1'b0);
        check("chk_32_0", pix_data, 12'hFFF);
        req(12'd32, 12'd32, 1'b0);
        check("chk_32_32", pix_data, 12'h000);
        req(12'd31, 12'd0, 1'b0);
        check("chk_31_0", pix_data, 12'h000);
        req(12'd0, 12'd32, 1'b0);
        check("chk_0_32", pix_data, 12'hFFF);

        // mode_next coincident with the tick-producing request.
        req(12'd799, 12'd599, 1'b1);
        check("tick2_pulse", frame_tick, 1'b1);
        check("tick2_mode", mode, 2'd2);
        check("tick2_pending", dut.pending, 1'b0);
        check("tick2_frame_cnt", dut.frame_cnt, 8'd2);

        req(12'hFFF, 12'hFFF, 1'b1);
        check("grad_pending", dut.pending, 1'b1);
        req(12'd128, 12'd192, 1'b0);
        check("grad_pixel", pix_data, 12'h230);

        // Asynchronous reset mid-frame, away from any clock edge.
        @(negedge vga_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pix_data", pix_data, 12'h000);
        check("rst_mode", mode, 2'd0);
        check("rst_box_x", dut.box_x, 12'd0);
        check("rst_box_y", dut.box_y, 12'd0);
        check("rst_frame_cnt", dut.frame_cnt, 8'd0);
        check("rst_pending", dut.pending, 1'b0);
        @(negedge vga_clk);
        rst_n = 1'b1;
        req(12'd0, 12'd0, 1'b0);
        check("post_rst_pixel", pix_data, 12'hFFF);

        // 400 frames; the first three ticks step the mode up to BOUNCE.
        for (int n = 1; n <= 400; n++) begin
            req(12'd799, 12'd599, (n <= 3) ? 1'b1 : 1'b0);
            if (n == 3)   check("bounce_mode", mode, 2'd3);
            if (n == 256) check("frame_cnt_wrap", dut.frame_cnt, 8'd0);
            if (n == 268) check("box_y_clamp", dut.box_y, 12'd536);
            if (n == 269) check("box_y_reverse", dut.box_y, 12'd534);
            if (n == 368) check("box_x_clamp", dut.box_x, 12'd736);
            if (n == 369) check("box_x_reverse", dut.box_x, 12'd734);
            if (n == 400) check("tick400_pulse", frame_tick, 1'b1);
        end
        check("box_x_f400", dut.box_x, 12'd672);
        check("box_y_f400", dut.box_y, 12'd272);
        req(12'd672, 12'd272, 1'b0);
        check("box_top_left", pix_data, 12'hFF0);
        req(12'd735, 12'd335, 1'b0);
        check("box_bot_right", pix_data, 12'hFF0);
        req(12'd736, 12'd272, 1'b0);
        check("box_right_out", pix_data, 12'h004);
        req(12'd671, 12'd272, 1'b0);
        check("box_left_out", pix_data, 12'h004);
        req(12'd672, 12'd336, 1'b0);
        check("box_below_out", pix_data, 12'h004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
